rom_loader: RTL and testbench

//  Boot-image writer for the instruction ROM. Receives a framed byte stream (from a

---
 rtl/rom_loader.sv | 168 ++++++++++++++++
 tb/tb_rom_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Boot-image loader: parses framed byte stream (SYNC, addr, count, words, checksum),
// writes 16-bit words to the instruction ROM and releases the core on a good checksum.
module rom_loader #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        clear,
  output logic        rom_wen,
  output logic [15:0] rom_addr,
  output logic [15:0] rom_data,
  output logic        core_run,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [7:0]  hi_q;
  logic [15:0] cur_addr_q;
  logic [15:0] remain_q;
  logic [15:0] acc_q;
  logic [15:0] tmo_q;
  logic        rom_wen_q;
  logic [15:0] rom_addr_q;
  logic [15:0] rom_data_q;
  logic        core_run_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] words_q;

  // Valid/ready: a byte moves only on a cycle where in_valid and in_ready are both high;
  // in_ready is low solely in DONE/ERR, so clear always wins over a pending byte there.
  logic        xfer;
  logic [15:0] word_d;
  logic        tmo_hit;

  assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign xfer     = in_valid && in_ready;
  assign word_d   = {hi_q, in_data};
  assign tmo_hit  = ({16'd0, tmo_q} == (TIMEOUT_CYC - 32'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      hi_q       <= 8'd0;
      cur_addr_q <= 16'd0;
      remain_q   <= 16'd0;
      acc_q      <= 16'd0;
      tmo_q      <= 16'd0;
      rom_wen_q  <= 1'b0;
      rom_addr_q <= 16'd0;
      rom_data_q <= 16'd0;
      core_run_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      words_q    <= 16'd0;
    end else begin
      rom_wen_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (xfer && (in_data == SYNC_BYTE)) begin
            state_q    <= S_HDR;
            core_run_q <= 1'b0;
            words_q    <= 16'd0;
            acc_q      <= 16'd0;
            idx_q      <= 2'd0;
            tmo_q      <= 16'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
          end
        end
        S_HDR, S_DATA, S_CSUM: begin
          if (xfer) begin
            tmo_q <= 16'd0;
            if (state_q == S_HDR) begin
              idx_q <= idx_q + 2'd1;
              case (idx_q)
                2'd0: cur_addr_q[15:8] <= in_data;
                2'd1: cur_addr_q[7:0]  <= in_data;
                2'd2: remain_q[15:8]   <= in_data;
                default: begin
                  remain_q[7:0] <= in_data;
                  idx_q         <= 2'd0;
                  state_q       <= ({remain_q[15:8], in_data} == 16'd0) ? S_CSUM : S_DATA;
                end
              endcase
            end else if (state_q == S_DATA) begin
              if (!idx_q[0]) begin
                hi_q  <= in_data;
                idx_q <= 2'd1;
              end else begin
                idx_q      <= 2'd0;
                rom_wen_q  <= 1'b1;
                rom_addr_q <= cur_addr_q;
                rom_data_q <= word_d;
                acc_q      <= acc_q + word_d;
                words_q    <= words_q + 16'd1;
                cur_addr_q <= cur_addr_q + 16'd1;
                remain_q   <= remain_q - 16'd1;
                if (remain_q == 16'd1) state_q <= S_CSUM;
              end
            end else begin
              if (!idx_q[0]) begin
                hi_q  <= in_data;
                idx_q <= 2'd1;
              end else begin
                idx_q <= 2'd0;
                if (word_d == acc_q) begin
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  core_run_q <= 1'b1;
                end else begin
                  state_q <= S_ERR;
                  error_q <= 1'b1;
                end
              end
            end
          end else if (tmo_hit) begin
            // Stalled link: abandon the frame; any write already strobed still lands.
            state_q <= S_ERR;
            error_q <= 1'b1;
            tmo_q   <= 16'd0;
            idx_q   <= 2'd0;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        S_DONE, S_ERR: begin
          if (clear) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_wen      = rom_wen_q;
  assign rom_addr     = rom_addr_q;
  assign rom_data     = rom_data_q;
  assign core_run     = core_run_q;
  assign busy         = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: frame loading, checksum pass/fail, address wrap,
// empty frames, stall timeout and asynchronous reset mid-frame.
module tb_rom_loader;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        clear;
  logic        rom_wen;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        core_run;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  int total;
  int bad;

  logic [7:0]  tx_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  rom_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clear(clear), .rom_wen(rom_wen), .rom_addr(rom_addr),
    .rom_data(rom_data), .core_run(core_run), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && rom_wen) got_q.push_back({rom_addr, rom_data});
  end

  // driver tasks
  task automatic drive_tx();
    while (tx_q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = tx_q.pop_front();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    settle();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if ({rom_wen, core_run, busy, done, error} !== 5'b0) begin bad++;
      $display("FAIL reset_flags got=%b exp=00000", {rom_wen, core_run, busy, done, error}); end
    total++; if ({rom_addr, rom_data, words_loaded} !== 48'h0) begin bad++;
      $display("FAIL reset_values got=%h exp=0", {rom_addr, rom_data, words_loaded}); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL reset_no_write got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_good_frame();
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
    exp_q = '{{16'h0100, 16'h1234}, {16'h0101, 16'hABCD}};
    got_q.delete();
    drive_tx();
    settle();
    total++; if (got_q.size() != exp_q.size()) begin bad++;
      $display("FAIL good_write_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL good_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if ({done, error, core_run, busy, in_ready} !== 5'b10100) begin bad++;
      $display("FAIL good_flags got=%b exp=10100", {done, error, core_run, busy, in_ready}); end
    total++; if (words_loaded !== 16'd2) begin bad++; $display("FAIL good_words got=%0d exp=2", words_loaded); end
  endtask

  task automatic test_bad_csum();
    pulse_clear();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00};
    exp_q = '{{16'h0100, 16'h1234}, {16'h0101, 16'hABCD}};
    got_q.delete();
    drive_tx();
    settle();
    total++; if (got_q.size() != exp_q.size()) begin bad++;
      $display("FAIL bad_write_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bad_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if ({done, error, core_run} !== 3'b010) begin bad++;
      $display("FAIL bad_flags got=%b exp=010", {done, error, core_run}); end
    // clear with a SYNC byte offered: clear wins, byte is not taken
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL err_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    #1;
    total++; if ({error, busy, in_ready} !== 3'b001) begin bad++;
      $display("FAIL clear_flags got=%b exp=001", {error, busy, in_ready}); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL clear_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_addr_wrap();
    tx_q = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    exp_q = '{{16'hFFFF, 16'h0001}, {16'h0000, 16'h0002}};
    got_q.delete();
    drive_tx();
    settle();
    total++; if (got_q.size() != exp_q.size()) begin bad++;
      $display("FAIL wrap_write_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if ({done, error, core_run} !== 3'b101) begin bad++;
      $display("FAIL wrap_flags got=%b exp=101", {done, error, core_run}); end
  endtask

  task automatic test_empty_frame();
    pulse_clear();
    total++; if (core_run !== 1'b1) begin bad++; $display("FAIL run_survives_clear got=%b exp=1", core_run); end
    tx_q = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    got_q.delete();
    drive_tx();
    settle();
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL empty_no_write got=%0d exp=0", got_q.size()); end
    total++; if ({done, error, core_run, words_loaded} !== {3'b101, 16'd0}) begin bad++;
      $display("FAIL empty_good got=%b/%0d exp=101/0", {done, error, core_run}, words_loaded); end
    pulse_clear();
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34};
    drive_tx();
    settle();
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL empty_bad_no_write got=%0d exp=0", got_q.size()); end
    total++; if ({done, error, core_run} !== 3'b010) begin bad++;
      $display("FAIL empty_bad got=%b exp=010", {done, error, core_run}); end
  endtask

  task automatic test_timeout();
    pulse_clear();
    tx_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h05, 8'h12};
    got_q.delete();
    drive_tx();
    repeat (15) @(posedge clk);
    #1;
    total++; if ({busy, error} !== 2'b10) begin bad++;
      $display("FAIL tmo_15_idle got=%b exp=10", {busy, error}); end
    @(posedge clk); #1;
    total++; if ({busy, error, done} !== 3'b010) begin bad++;
      $display("FAIL tmo_16_idle got=%b exp=010", {busy, error, done}); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL tmo_no_write got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    pulse_clear();
    tx_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    got_q.delete();
    drive_tx();
    #2;
    total++; if ({busy, words_loaded, rom_addr} !== {1'b1, 16'd1, 16'h0010}) begin bad++;
      $display("FAIL pre_reset got=%b/%0d/%h exp=1/1/0010", busy, words_loaded, rom_addr); end
    reset_n = 1'b0;
    #1;
    total++; if ({rom_wen, core_run, busy, done, error, in_ready} !== 6'b000001) begin bad++;
      $display("FAIL async_reset_flags got=%b exp=000001", {rom_wen, core_run, busy, done, error, in_ready}); end
    total++; if ({rom_addr, rom_data, words_loaded} !== 48'h0) begin bad++;
      $display("FAIL async_reset_values got=%h exp=0", {rom_addr, rom_data, words_loaded}); end
    total++; if (got_q.size() != 1 || got_q[0] !== {16'h0010, 16'h1234}) begin bad++;
      $display("FAIL partial_image got=%0d writes exp=1 (0010,1234)", got_q.size()); end
    @(negedge clk);
    reset_n = 1'b1;
    settle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_addr_wrap();
    test_empty_frame();
    test_timeout();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
